sq_commit_ctrl: RTL and testbench

SQ_COMMIT_CTRL -- requirements
Module: sq_commit_ctrl

---
 rtl/sq_commit_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sq_commit_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_commit_ctrl.sv
// ---------------------------------------------------------------------------
// sq_commit_ctrl
//
// Purpose:
//   Drains retired stores from the head of a store queue into a single shared
//   data-memory port while also serving load reads through that same port.
//   Stores that have retired but not yet been written are counted in
//   'pending'. Loads normally win the port, but a starvation counter makes
//   sure a drainable store gets through after STARVE_MAX back-to-back load
//   grants. A full pending count also forces the store through.
//
// Ports:
//   clk, rst          - single clock (rising edge), async active-high reset
//   commit_req        - retirement stage retires the store at the SQ head
//   commit_ready      - commit accepted this cycle
//   head_valid        - SQ head entry is valid
//   head_data_valid   - SQ head entry has its store data
//   head_addr/data    - SQ head entry address and data
//   sq_del            - one-cycle pulse dequeuing the SQ head
//   ld_req/ld_addr    - load read request and address
//   ld_gnt            - load granted this cycle
//   ld_valid/ld_data  - load result pulse and held load data
//   mem_req/we/addr/wd- shared data-memory request
//   mem_ack/mem_rd    - memory acknowledge and read data
//   pending           - retired-but-undrained store count
//   busy              - controller has a memory request in flight
// ---------------------------------------------------------------------------
module sq_commit_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int PEND_MAX   = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_req,
  output logic              commit_ready,
  input  logic              head_valid,
  input  logic              head_data_valid,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [DATA_W-1:0] head_data,
  output logic              sq_del,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [2:0]        pending,
  output logic              busy
);

  localparam int StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [2:0]         PendMax   = 3'(PEND_MAX);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ST_WR = 2'd1,
    LD_RD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          pending_q, pending_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wd_q;
  logic [DATA_W-1:0]   ld_data_q;
  logic                sq_del_q;
  logic                ld_valid_q;

  logic store_elig;
  logic go_st;
  logic go_ld;
  logic commit_acc;
  logic drain;

  // Arbitration for the shared port. While sq_del is high the SQ head still
  // shows the store that was just written (it leaves the queue at the end of
  // this cycle), so it must not be picked up a second time.
  always_comb begin
    store_elig = (pending_q != 3'd0) & head_valid & head_data_valid & ~sq_del_q;
    go_st      = (state_q == IDLE) & store_elig &
                 (~ld_req | (pending_q == PendMax) | (starve_cnt_q == StarveMax));
    go_ld      = (state_q == IDLE) & ~go_st & ld_req;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one request in flight at a time, mem_ack only matters
  // while a request is outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go_st) begin
          state_d = ST_WR;
        end else if (go_ld) begin
          state_d = LD_RD;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      LD_RD: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs. The grant is combinational so the request follows
  // one cycle later; it is masked during reset so it reads zero then.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    ld_gnt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_gnt = go_ld & ~rst;
      end
      ST_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        busy    = 1'b1;
      end
      LD_RD: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Request address/data are captured at grant time and held until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else if (go_st) begin
      mem_addr_q <= head_addr;
      mem_wd_q   <= head_data;
    end else if (go_ld) begin
      mem_addr_q <= ld_addr;
    end
  end

  // Completion pulses land the cycle after the ack edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_del_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      sq_del_q   <= (state_q == ST_WR) & mem_ack;
      ld_valid_q <= (state_q == LD_RD) & mem_ack;
      if ((state_q == LD_RD) & mem_ack) begin
        ld_data_q <= mem_rd;
      end
    end
  end

  // Pending count drops on the sq_del cycle, which is also the cycle that
  // frees a slot for a commit when the count is full; a commit and a drain
  // together cancel out.
  always_comb begin
    commit_ready = (pending_q != PendMax) | sq_del_q;
    commit_acc   = commit_req & commit_ready;
    drain        = sq_del_q & (pending_q != 3'd0);
    pending_d    = pending_q;
    unique case ({commit_acc, drain})
      2'b10: begin
        if (pending_q != PendMax) begin
          pending_d = pending_q + 3'd1;
        end
      end
      2'b01:   pending_d = pending_q - 3'd1;
      default: pending_d = pending_q;
    endcase
  end

  // Starvation counter: counts loads granted ahead of a drainable store.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (go_st) begin
      starve_cnt_d = '0;
    end else if (go_ld & store_elig) begin
      if (starve_cnt_q != StarveMax) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end else if ((state_q == IDLE) & ~store_elig) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 3'd0;
      starve_cnt_q <= '0;
    end else begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign sq_del   = sq_del_q;
  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_sq_commit_ctrl.sv
// Directed testbench for sq_commit_ctrl: store drain, load starvation limit,
// full pending count, data-not-ready head and mid-transaction reset.
module tb_sq_commit_ctrl;

  logic        clk;
  logic        rst;
  logic        commitReq;
  logic        commitReady;
  logic        headValid;
  logic        headDataValid;
  logic [7:0]  headAddr;
  logic [31:0] headData;
  logic        sqDel;
  logic        ldReq;
  logic [7:0]  ldAddr;
  logic        ldGnt;
  logic        ldValid;
  logic [31:0] ldData;
  logic        memReq;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [31:0] memWd;
  logic        memAck;
  logic [31:0] memRd;
  logic [2:0]  pending;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  sq_commit_ctrl #(
    .ADDR_W(8), .DATA_W(32), .PEND_MAX(7), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .commit_req(commitReq), .commit_ready(commitReady),
    .head_valid(headValid), .head_data_valid(headDataValid),
    .head_addr(headAddr), .head_data(headData),
    .sq_del(sqDel),
    .ld_req(ldReq), .ld_addr(ldAddr), .ld_gnt(ldGnt),
    .ld_valid(ldValid), .ld_data(ldData),
    .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wd(memWd),
    .mem_ack(memAck), .mem_rd(memRd),
    .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs and samples sit 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cr, input logic hv, input logic hdv,
                               input logic [7:0] ha, input logic [31:0] hd);
    commitReq     = cr;
    headValid     = hv;
    headDataValid = hdv;
    headAddr      = ha;
    headData      = hd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ldReq  = 1'b1;
    ldAddr = 8'h00;
    memAck = 1'b0;
    memRd  = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Reset values, with a load request present to show the grant is masked.
    tick();
    tick();
    checkOutput("rst ld_gnt", 32'(ldGnt), 32'd0);
    checkOutput("rst mem_req", 32'(memReq), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst pending", 32'(pending), 32'd0);
    checkOutput("rst sq_del", 32'(sqDel), 32'd0);
    checkOutput("rst ld_valid", 32'(ldValid), 32'd0);
    checkOutput("rst commit_ready", 32'(commitReady), 32'd1);
    ldReq = 1'b0;
    rst   = 1'b0;
    tick();

    // Single store commit and drain with a two-cycle memory latency.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    #1;
    checkOutput("t1 commit_ready", 32'(commitReady), 32'd1);
    tick();
    commitReq = 1'b0;
    checkOutput("t1 pending inc", 32'(pending), 32'd1);
    checkOutput("t1 no ld_gnt", 32'(ldGnt), 32'd0);
    tick();
    checkOutput("t1 mem_req", 32'(memReq), 32'd1);
    checkOutput("t1 mem_we", 32'(memWe), 32'd1);
    checkOutput("t1 mem_addr", 32'(memAddr), 32'h10);
    checkOutput("t1 mem_wd", memWd, 32'hDEADBEEF);
    checkOutput("t1 busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t1 mem_addr held", 32'(memAddr), 32'h10);
    checkOutput("t1 sq_del before ack", 32'(sqDel), 32'd0);
    memAck = 1'b1;
    tick();
    memAck    = 1'b0;
    headValid = 1'b0;
    checkOutput("t1 sq_del pulse", 32'(sqDel), 32'd1);
    checkOutput("t1 mem_req after ack", 32'(memReq), 32'd0);
    tick();
    checkOutput("t1 sq_del one cycle", 32'(sqDel), 32'd0);
    checkOutput("t1 pending drained", 32'(pending), 32'd0);

    // Two stores pending but data not yet ready; then loads compete.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h44, 32'h12345678);
    tick();
    tick();
    commitReq = 1'b0;
    checkOutput("t2 pending 2", 32'(pending), 32'd2);
    checkOutput("t2 idle", 32'(busy), 32'd0);
    headDataValid = 1'b1;
    ldReq  = 1'b1;
    ldAddr = 8'h20;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checkOutput($sformatf("t2 ld_gnt %0d", i), 32'(ldGnt), 32'd1);
      tick();
      checkOutput($sformatf("t2 ld mem_we %0d", i), 32'(memWe), 32'd0);
      checkOutput($sformatf("t2 ld mem_addr %0d", i), 32'(memAddr), 32'h20);
      memAck = 1'b1;
      memRd  = 32'hA0000000 + 32'(i);
      tick();
      memAck = 1'b0;
      checkOutput($sformatf("t2 ld_valid %0d", i), 32'(ldValid), 32'd1);
      checkOutput($sformatf("t2 ld_data %0d", i), ldData, 32'hA0000000 + 32'(i));
    end
    #1;
    checkOutput("t2 starve blocks load", 32'(ldGnt), 32'd0);
    checkOutput("t2 starve at max", 32'(dut.starve_cnt_q), 32'd4);
    tick();
    checkOutput("t2 st mem_we", 32'(memWe), 32'd1);
    checkOutput("t2 st mem_addr", 32'(memAddr), 32'h44);
    checkOutput("t2 st mem_wd", memWd, 32'h12345678);
    checkOutput("t2 starve cleared", 32'(dut.starve_cnt_q), 32'd0);
    checkOutput("t2 ld_valid dropped", 32'(ldValid), 32'd0);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    ldReq  = 1'b0;
    #1;
    checkOutput("t2 sq_del", 32'(sqDel), 32'd1);
    checkOutput("t2 no regrant same head", 32'(ldGnt), 32'd0);
    tick();
    checkOutput("t2 pending 1", 32'(pending), 32'd1);
    checkOutput("t2 no rewrite", 32'(memReq), 32'd0);

    // Remaining store has no data: only loads are served.
    headDataValid = 1'b0;
    ldReq  = 1'b1;
    ldAddr = 8'h30;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("t3 ld_gnt %0d", i), 32'(ldGnt), 32'd1);
      tick();
      checkOutput($sformatf("t3 ld only %0d", i), 32'(memWe), 32'd0);
      memAck = 1'b1;
      memRd  = 32'h5555AAA0 + 32'(i);
      tick();
      memAck = 1'b0;
      checkOutput($sformatf("t3 ld_data %0d", i), ldData, 32'h5555AAA0 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h50, 32'hCAFEF00D);
    ldReq = 1'b0;
    tick();
    checkOutput("t3 st mem_we", 32'(memWe), 32'd1);
    checkOutput("t3 st mem_addr", 32'(memAddr), 32'h50);
    checkOutput("t3 st mem_wd", memWd, 32'hCAFEF00D);
    checkOutput("t3 ld_data held", ldData, 32'h5555AAA1);
    memAck = 1'b1;
    tick();
    memAck    = 1'b0;
    headValid = 1'b0;
    checkOutput("t3 sq_del", 32'(sqDel), 32'd1);
    tick();
    checkOutput("t3 pending 0", 32'(pending), 32'd0);

    // Fill pending to the limit while a store waits for its ack.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h60, 32'h0BADCAFE);
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    checkOutput("t4 pending full", 32'(pending), 32'd7);
    checkOutput("t4 commit_ready low", 32'(commitReady), 32'd0);
    checkOutput("t4 in store", 32'(memWe), 32'd1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("t4 pending held at full", 32'(pending), 32'd7);
    checkOutput("t4 sq_del", 32'(sqDel), 32'd1);
    checkOutput("t4 commit_ready via sq_del", 32'(commitReady), 32'd1);
    tick();
    commitReq = 1'b0;
    ldReq     = 1'b1;
    ldAddr    = 8'h70;
    #1;
    checkOutput("t4 pending stays 7", 32'(pending), 32'd7);
    checkOutput("t4 commit_ready low again", 32'(commitReady), 32'd0);
    checkOutput("t4 full forces store", 32'(ldGnt), 32'd0);
    tick();
    ldReq = 1'b0;
    checkOutput("t4 store entered", 32'(memWe), 32'd1);

    // Reset in the middle of the store, then a stray ack.
    rst = 1'b1;
    #1;
    checkOutput("t5 mem_req", 32'(memReq), 32'd0);
    checkOutput("t5 mem_we", 32'(memWe), 32'd0);
    checkOutput("t5 busy", 32'(busy), 32'd0);
    checkOutput("t5 pending", 32'(pending), 32'd0);
    checkOutput("t5 mem_addr", 32'(memAddr), 32'd0);
    checkOutput("t5 mem_wd", memWd, 32'd0);
    checkOutput("t5 ld_data", ldData, 32'd0);
    checkOutput("t5 sq_del", 32'(sqDel), 32'd0);
    #2;
    rst       = 1'b0;
    headValid = 1'b0;
    memAck    = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("t5 stray ack sq_del", 32'(sqDel), 32'd0);
    checkOutput("t5 stray ack ld_valid", 32'(ldValid), 32'd0);
    checkOutput("t5 stray ack mem_req", 32'(memReq), 32'd0);
    tick();
    checkOutput("t5 pending after stray", 32'(pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
